controller: RTL and testbench

- Top-level sequencing FSM for the two-operand compute datapath.
- Accepts 8 operand-A bytes, then 8 operand-B bytes, from the input interface. For each byte it generates a memory write address and strobe; the memory takes its data directly from input_value.
- After the last write it launches the compute engine, waits for comp_done, latches comp_result and hands it to the display.

---
 rtl/controller.sv | 148 ++++++++++++++
 tb/tb_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// Sequencing FSM for the two-operand compute datapath: loads A then B into memory,
// launches the compute engine and presents the result. Optional: CTRL_DONE_TIMEOUT_EN.
module controller #(
  parameter int unsigned N_PER_OPERAND = 8,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned DATA_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] input_value,
  input  logic              input_value_ready,
  output logic              input_enable,
  output logic [ADDR_W-1:0] ctrl_mem_addr,
  output logic              ctrl_mem_wr,
  output logic              mode_compute,
  output logic              comp_start,
  input  logic              comp_done,
  input  logic [DATA_W-1:0] comp_result,
  output logic              display_enable,
  output logic [DATA_W-1:0] display_value
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N_PER_OPERAND - 1);
  localparam logic [ADDR_W-1:0] LAST_B = ADDR_W'(2 * N_PER_OPERAND - 1);

  typedef enum logic [2:0] {
    ST_LOAD_A,
    ST_LOAD_B,
    ST_START,
    ST_WAIT,
    ST_DISPLAY
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic              input_enable_q, input_enable_d;
  logic              mode_compute_q, mode_compute_d;
  logic              comp_start_q, comp_start_d;
  logic              display_enable_q, display_enable_d;

  // The memory samples input_value directly; it is not stored here.
  logic unused_input_value;
  assign unused_input_value = ^input_value;

`ifdef CTRL_DONE_TIMEOUT_EN
  localparam logic [DATA_W-1:0] TIMEOUT_VALUE = DATA_W'(8'hEE);
  logic [7:0] tmo_q, tmo_d;
`endif

  // Next-state, write counter, result latch and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
`ifdef CTRL_DONE_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif

    unique case (state_q)
      ST_LOAD_A: begin
        if (input_value_ready) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_A) state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (input_value_ready) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_B) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
      end
      ST_START, ST_WAIT: begin
        if (comp_done) begin
          disp_d  = comp_result;
          state_d = ST_DISPLAY;
        end else if (state_q == ST_START) begin
          state_d = ST_WAIT;
        end
`ifdef CTRL_DONE_TIMEOUT_EN
        else if (tmo_q == 8'd254) begin
          disp_d  = TIMEOUT_VALUE;
          state_d = ST_DISPLAY;
        end
        if (state_q == ST_WAIT) tmo_d = tmo_q + 8'd1;
`endif
      end
      ST_DISPLAY: begin
        if (input_value_ready) begin
          state_d = ST_LOAD_A;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_LOAD_A;
        cnt_d   = '0;
      end
    endcase

`ifdef CTRL_DONE_TIMEOUT_EN
    if (state_d == ST_START) tmo_d = '0;
`endif

    input_enable_d   = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
    mode_compute_d   = (state_d == ST_START) || (state_d == ST_WAIT);
    comp_start_d     = (state_d == ST_START);
    display_enable_d = (state_d == ST_DISPLAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_LOAD_A;
      cnt_q            <= '0;
      disp_q           <= '0;
      input_enable_q   <= 1'b1;
      mode_compute_q   <= 1'b0;
      comp_start_q     <= 1'b0;
      display_enable_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      disp_q           <= disp_d;
      input_enable_q   <= input_enable_d;
      mode_compute_q   <= mode_compute_d;
      comp_start_q     <= comp_start_d;
      display_enable_q <= display_enable_d;
    end
  end

`ifdef CTRL_DONE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`endif

  assign input_enable   = input_enable_q;
  assign ctrl_mem_addr  = cnt_q;
  assign ctrl_mem_wr    = input_enable_q & input_value_ready;
  assign mode_compute   = mode_compute_q;
  assign comp_start     = comp_start_q;
  assign display_enable = display_enable_q;
  assign display_value  = disp_q;

endmodule

// File: tb/tb_controller.sv
// Directed self-checking bench for controller; expected values are hand-derived.
// Build with CTRL_DONE_TIMEOUT_EN defined to exercise the WAIT timeout path.
module tb_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] input_value;
  logic       input_value_ready;
  logic       input_enable;
  logic [3:0] ctrl_mem_addr;
  logic       ctrl_mem_wr;
  logic       mode_compute;
  logic       comp_start;
  logic       comp_done;
  logic [7:0] comp_result;
  logic       display_enable;
  logic [7:0] display_value;

  int n_checks = 0;
  int n_errors = 0;

  controller dut (
    .clk              (clk),
    .rst              (rst),
    .input_value      (input_value),
    .input_value_ready(input_value_ready),
    .input_enable     (input_enable),
    .ctrl_mem_addr    (ctrl_mem_addr),
    .ctrl_mem_wr      (ctrl_mem_wr),
    .mode_compute     (mode_compute),
    .comp_start       (comp_start),
    .comp_done        (comp_done),
    .comp_result      (comp_result),
    .display_enable   (display_enable),
    .display_value    (display_value)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle write pulse; checks the strobe and address before the edge.
  task automatic load_byte(input logic [7:0] val, input logic [3:0] exp_addr);
    input_value       = val;
    input_value_ready = 1'b1;
    #1;
    check_eq("wr_strobe", 32'(ctrl_mem_wr), 32'd1);
    check_eq("wr_addr", 32'(ctrl_mem_addr), 32'(exp_addr));
    check_eq("load_en", 32'(input_enable), 32'd1);
    tick();
    input_value_ready = 1'b0;
  endtask

  task automatic load_all(input logic [3:0] first_addr);
    for (int i = int'(first_addr); i < 16; i++) load_byte(8'(i + 1), 4'(i));
  endtask

  initial begin
    rst               = 1'b0;
    input_value       = '0;
    input_value_ready = 1'b0;
    comp_done         = 1'b0;
    comp_result       = '0;
    #12;
    check_eq("rst_en", 32'(input_enable), 32'd1);
    check_eq("rst_addr", 32'(ctrl_mem_addr), 32'd0);
    check_eq("rst_others", 32'({ctrl_mem_wr, mode_compute, comp_start, display_enable}), 32'd0);
    check_eq("rst_disp", 32'(display_value), 32'd0);
    rst = 1'b1;
    tick();
    check_eq("rel_en", 32'(input_enable), 32'd1);
    check_eq("rel_addr", 32'(ctrl_mem_addr), 32'd0);

    // Partial load then reset mid-LOAD_B.
    for (int i = 0; i < 11; i++) load_byte(8'(i), 4'(i));
    check_eq("midb_addr", 32'(ctrl_mem_addr), 32'd11);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_addr", 32'(ctrl_mem_addr), 32'd0);
    check_eq("abort_en", 32'(input_enable), 32'd1);
    tick();
    rst = 1'b1;
    tick();

    // Operand A: values 1..8 at addresses 0..7, with a stray comp_done ignored.
    for (int i = 0; i < 8; i++) begin
      load_byte(8'(i + 1), 4'(i));
      check_eq("a_en_held", 32'(input_enable), 32'd1);
      if (i == 3) begin
        comp_done   = 1'b1;
        comp_result = 8'h55;
        tick();
        comp_done = 1'b0;
        check_eq("done_ign_addr", 32'(ctrl_mem_addr), 32'd4);
        check_eq("done_ign_disp", 32'({display_enable, mode_compute}), 32'd0);
      end
    end
    check_eq("b_entry_addr", 32'(ctrl_mem_addr), 32'd8);
    check_eq("b_entry_en", 32'(input_enable), 32'd1);

    // Operand B: values 11..18 at addresses 8..15.
    for (int i = 0; i < 8; i++) load_byte(8'(11 + i), 4'(8 + i));
    check_eq("start_pulse", 32'(comp_start), 32'd1);
    check_eq("start_mode", 32'(mode_compute), 32'd1);
    check_eq("start_en", 32'(input_enable), 32'd0);
    check_eq("start_addr", 32'(ctrl_mem_addr), 32'd0);
    input_value_ready = 1'b1;
    #1;
    check_eq("start_no_wr", 32'(ctrl_mem_wr), 32'd0);
    tick();
    input_value_ready = 1'b0;
    check_eq("start_one_cycle", 32'(comp_start), 32'd0);
    check_eq("wait_mode", 32'(mode_compute), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check_eq("wait_hold", 32'({mode_compute, display_enable}), 32'b10);
    comp_done   = 1'b1;
    comp_result = 8'hFF;
    tick();
    comp_done   = 1'b0;
    comp_result = 8'h00;
    check_eq("disp_en", 32'(display_enable), 32'd1);
    check_eq("disp_val", 32'(display_value), 32'hFF);
    check_eq("disp_mode", 32'(mode_compute), 32'd0);
    tick();
    check_eq("disp_stable", 32'(display_value), 32'hFF);

    // Restart from DISPLAY; the ready pulse is not a write.
    input_value_ready = 1'b1;
    #1;
    check_eq("restart_no_wr", 32'(ctrl_mem_wr), 32'd0);
    tick();
    input_value_ready = 1'b0;
    check_eq("restart_en", 32'(input_enable), 32'd1);
    check_eq("restart_addr", 32'(ctrl_mem_addr), 32'd0);
    check_eq("restart_disp_off", 32'(display_enable), 32'd0);

    // Ready held three cycles gives three back-to-back writes.
    input_value_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("held_wr", 32'(ctrl_mem_wr), 32'd1);
      check_eq("held_addr", 32'(ctrl_mem_addr), 32'(i));
      tick();
    end
    input_value_ready = 1'b0;
    #1;
    check_eq("held_end_addr", 32'(ctrl_mem_addr), 32'd3);

    // comp_done coincident with START goes straight to DISPLAY.
    load_all(4'd3);
    check_eq("start2", 32'(comp_start), 32'd1);
    comp_done   = 1'b1;
    comp_result = 8'h3C;
    tick();
    comp_done = 1'b0;
    check_eq("fast_disp_en", 32'(display_enable), 32'd1);
    check_eq("fast_disp_val", 32'(display_value), 32'h3C);
    check_eq("fast_mode", 32'(mode_compute), 32'd0);

    // No comp_done: timeout path or indefinite wait depending on build.
    input_value_ready = 1'b1;
    tick();
    input_value_ready = 1'b0;
    load_all(4'd0);
    check_eq("start3", 32'(comp_start), 32'd1);
`ifdef CTRL_DONE_TIMEOUT_EN
    for (int i = 0; i < 255; i++) tick();
    check_eq("tmo_not_yet", 32'({mode_compute, display_enable}), 32'b10);
    tick();
    check_eq("tmo_disp_en", 32'(display_enable), 32'd1);
    check_eq("tmo_disp_val", 32'(display_value), 32'hEE);
    input_value_ready = 1'b1;
    tick();
    input_value_ready = 1'b0;
    check_eq("tmo_restart_en", 32'(input_enable), 32'd1);
    check_eq("tmo_restart_addr", 32'(ctrl_mem_addr), 32'd0);
`else
    for (int i = 0; i < 300; i++) tick();
    check_eq("wait_forever", 32'({mode_compute, display_enable}), 32'b10);
    check_eq("wait_disp_val", 32'(display_value), 32'h3C);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
